mips_bus_arbiter: RTL and testbench

- Shares the single Avalon-style memory master of `mips_cpu_bus` between two internal requesters: instruction fetch (F) and data load/store (D).
- Sits between the CPU core's fetch/memory stages and the external bus (`address`/`read`/`write`/`waitrequest`/`writedata`/`byteenable`/`readdata`).
- Locks a grant for the whole duration of a transfer, routes the response back to the owner, and aborts transfers that stall too long.

---
 rtl/mips_bus_arbiter_pkg.sv | 23 ++
 rtl/mips_bus_arbiter_if.sv | 25 ++
 rtl/mips_bus_arbiter_pick.sv | 29 ++
 rtl/mips_bus_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mips_bus_arbiter.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_bus_arbiter_pkg.sv
// Shared types and constants for the two-requester MIPS bus arbiter.
// Provides the arbiter state and requester id enums, bus widths, and the
// full-word byte enable used by instruction fetch.
package mips_bus_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned CNT_W  = 16;

    localparam logic [BE_W-1:0] BE_WORD = BE_W'(4'b1111);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    typedef enum logic {
        REQ_F = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

endpackage

// File: rtl/mips_bus_arbiter_if.sv
// Avalon-style memory bus between the arbiter (master) and the memory (slave).
// Signals: address/read/write/writedata/byteenable driven by the master,
// waitrequest/readdata returned by the slave.
interface mips_bus_if;
    import mips_bus_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [BE_W-1:0]   byteenable;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );

endinterface

// File: rtl/mips_bus_arbiter_pick.sv
// Combinational winner select between fetch (F) and data (D) requesters.
// Ports: f_req/d_req request flags, last_grant of the previous transfer,
// winner = selected requester (REQ_F when nobody requests; callers gate it).
module mips_arb_pick
    import mips_bus_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic    f_req,
    input  logic    d_req,
    input  req_id_t last_grant,
    output req_id_t winner
);

    // On contention: alternate away from last_grant, or fixed D priority.
    always_comb begin
        winner = REQ_F;
        if (d_req && !f_req) begin
            winner = REQ_D;
        end else if (d_req && f_req) begin
            if (ROUND_ROBIN) begin
                winner = (last_grant == REQ_F) ? REQ_D : REQ_F;
            end else begin
                winner = REQ_D;
            end
        end
    end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Shares the CPU's single memory bus master between instruction fetch (F)
// and data load/store (D). The grant is chosen combinationally in IDLE so a
// zero-wait transfer completes in the cycle it is requested; a stalled
// transfer locks the owner until waitrequest drops or the timeout aborts it.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   f_*                 : fetch requester (read-only) and its response
//   d_*                 : data requester and its response
//   bus                 : master side of the external memory bus
//   grant_d             : D owns or is being granted the bus
//   bus_error           : sticky timeout / protocol-violation flag
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int unsigned ROUND_ROBIN    = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] f_address,
    input  logic              f_read,
    output logic              f_waitrequest,
    output logic [DATA_W-1:0] f_readdata,
    input  logic [ADDR_W-1:0] d_address,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [DATA_W-1:0] d_writedata,
    input  logic [BE_W-1:0]   d_byteenable,
    output logic              d_waitrequest,
    output logic [DATA_W-1:0] d_readdata,
    mips_bus_if.master        bus,
    output logic              grant_d,
    output logic              bus_error
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

    arb_state_t       state;
    req_id_t          owner;
    req_id_t          last_grant;
    logic [CNT_W-1:0] cnt;

    logic    f_req;
    logic    d_req;
    req_id_t winner;
    req_id_t sel;
    logic    active;
    logic    sel_d;
    logic    timeout;
    logic    complete;
    logic    done;
    logic    violation;

    assign f_req = f_read;
    assign d_req = d_read | d_write;

    mips_arb_pick #(
        .ROUND_ROBIN (ROUND_ROBIN != 0)
    ) u_pick (
        .f_req      (f_req),
        .d_req      (d_req),
        .last_grant (last_grant),
        .winner     (winner)
    );

    // Current bus user: the locked owner, or the IDLE arbitration winner.
    always_comb begin
        active = 1'b0;
        sel    = winner;
        if (state == LOCKED) begin
            active = 1'b1;
            sel    = owner;
        end else begin
            active = f_req | d_req;
        end
    end

    assign sel_d     = (sel == REQ_D);
    assign timeout   = (state == LOCKED) && bus.waitrequest && (cnt == TIMEOUT_CNT);
    assign complete  = active && !bus.waitrequest;
    assign done      = complete || timeout;
    assign violation = active && sel_d && d_read && d_write;

    // Bus drive: owner's live inputs; read+write together is issued as a write.
    always_comb begin
        bus.address    = '0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.writedata  = '0;
        bus.byteenable = '0;
        if (!reset && active && !timeout) begin
            if (sel_d) begin
                bus.address    = d_address;
                bus.read       = d_read && !d_write;
                bus.write      = d_write;
                bus.writedata  = d_writedata;
                bus.byteenable = d_byteenable;
            end else begin
                bus.address    = f_address;
                bus.read       = f_read;
                bus.byteenable = BE_WORD;
            end
        end
    end

    // Requester responses; an aborted transfer returns zero data.
    always_comb begin
        f_waitrequest = 1'b1;
        f_readdata    = '0;
        d_waitrequest = 1'b1;
        d_readdata    = '0;
        grant_d       = 1'b0;
        if (!reset) begin
            grant_d = active && sel_d;
            if (done) begin
                if (sel_d) begin
                    d_waitrequest = 1'b0;
                    d_readdata    = complete ? bus.readdata : '0;
                end else begin
                    f_waitrequest = 1'b0;
                    f_readdata    = complete ? bus.readdata : '0;
                end
            end
        end
    end

    // Arbiter state, ownership lock, timeout counter and sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= REQ_F;
            last_grant <= REQ_F;
            cnt        <= '0;
            bus_error  <= 1'b0;
        end else begin
            if (violation || timeout) begin
                bus_error <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (active) begin
                        if (bus.waitrequest) begin
                            state <= LOCKED;
                            owner <= winner;
                            cnt   <= CNT_W'(1);
                        end else begin
                            last_grant <= winner;
                        end
                    end
                end
                LOCKED: begin
                    cnt <= cnt + CNT_W'(1);
                    if (done) begin
                        state      <= IDLE;
                        last_grant <= owner;
                        cnt        <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Self-checking bench for mips_bus_arbiter: a round-robin instance and a
// fixed-priority instance share one stimulus stream and one slave response.
// Directed vectors, corner-case sequences and random traffic are checked
// against a transaction-level reference model of each instance.
module tb_mips_bus_arbiter;

    localparam int unsigned TMO = 16;

    logic        clk;
    logic        reset;
    logic [31:0] f_address;
    logic        f_read;
    logic [31:0] d_address;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_writedata;
    logic [3:0]  d_byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    logic        rr_f_wait, rr_d_wait, rr_grant_d, rr_bus_error;
    logic [31:0] rr_f_rd, rr_d_rd;
    logic        fp_f_wait, fp_d_wait, fp_grant_d, fp_bus_error;
    logic [31:0] fp_f_rd, fp_d_rd;

    mips_bus_if bus_rr ();
    mips_bus_if bus_fp ();

    assign bus_rr.waitrequest = waitrequest;
    assign bus_rr.readdata    = readdata;
    assign bus_fp.waitrequest = waitrequest;
    assign bus_fp.readdata    = readdata;

    mips_bus_arbiter #(.ROUND_ROBIN(1), .TIMEOUT_CYCLES(TMO)) dut_rr (
        .clk(clk), .reset(reset),
        .f_address(f_address), .f_read(f_read),
        .f_waitrequest(rr_f_wait), .f_readdata(rr_f_rd),
        .d_address(d_address), .d_read(d_read), .d_write(d_write),
        .d_writedata(d_writedata), .d_byteenable(d_byteenable),
        .d_waitrequest(rr_d_wait), .d_readdata(rr_d_rd),
        .bus(bus_rr), .grant_d(rr_grant_d), .bus_error(rr_bus_error)
    );

    mips_bus_arbiter #(.ROUND_ROBIN(0), .TIMEOUT_CYCLES(TMO)) dut_fp (
        .clk(clk), .reset(reset),
        .f_address(f_address), .f_read(f_read),
        .f_waitrequest(fp_f_wait), .f_readdata(fp_f_rd),
        .d_address(d_address), .d_read(d_read), .d_write(d_write),
        .d_writedata(d_writedata), .d_byteenable(d_byteenable),
        .d_waitrequest(fp_d_wait), .d_readdata(fp_d_rd),
        .bus(bus_fp), .grant_d(fp_grant_d), .bus_error(fp_bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] address;
        logic        read;
        logic        write;
        logic [31:0] writedata;
        logic [3:0]  byteenable;
        logic        f_wait;
        logic [31:0] f_rd;
        logic        d_wait;
        logic [31:0] d_rd;
        logic        grant_d;
        logic        bus_error;
        int          who;
        bit          finish;
        bit          abort;
        bit          viol;
    } exp_t;

    // Per instance (0 = round robin, 1 = D priority): transfer in flight,
    // its owner (0 = F, 1 = D), cycles it has been stalled, previous winner.
    bit m_busy [2];
    int m_owner [2];
    int m_age [2];
    int m_last [2];
    bit m_err [2];
    bit f_hold;
    bit d_hold;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i]  = 1'b0;
            m_owner[i] = 0;
            m_age[i]   = 0;
            m_last[i]  = 0;
            m_err[i]   = 1'b0;
        end
        f_hold = 1'b0;
        d_hold = 1'b0;
    endtask

    function automatic exp_t model_eval(input int i);
        exp_t e;
        bit   dreq;
        int   who;
        dreq = (d_read === 1'b1) || (d_write === 1'b1);
        if (m_busy[i])                     who = m_owner[i];
        else if (f_read && dreq)           who = (i == 0 && m_last[i] == 1) ? 0 : 1;
        else if (dreq)                     who = 1;
        else if (f_read)                   who = 0;
        else                               who = -1;
        e.who        = who;
        e.abort      = m_busy[i] && waitrequest && (m_age[i] == int'(TMO));
        e.finish     = (who >= 0) && !waitrequest;
        e.viol       = (who == 1) && d_read && d_write;
        e.address    = 32'h0;
        e.read       = 1'b0;
        e.write      = 1'b0;
        e.writedata  = 32'h0;
        e.byteenable = 4'h0;
        e.f_wait     = 1'b1;
        e.f_rd       = 32'h0;
        e.d_wait     = 1'b1;
        e.d_rd       = 32'h0;
        e.grant_d    = (who == 1);
        e.bus_error  = m_err[i];
        if (who == 1 && !e.abort) begin
            e.address    = d_address;
            e.write      = d_write;
            e.read       = d_read && !d_write;
            e.writedata  = d_writedata;
            e.byteenable = d_byteenable;
        end else if (who == 0 && !e.abort) begin
            e.address    = f_address;
            e.read       = f_read;
            e.byteenable = 4'hF;
        end
        if (e.finish || e.abort) begin
            if (who == 1) begin
                e.d_wait = 1'b0;
                e.d_rd   = e.finish ? readdata : 32'h0;
            end else begin
                e.f_wait = 1'b0;
                e.f_rd   = e.finish ? readdata : 32'h0;
            end
        end
        return e;
    endfunction

    task automatic model_update(input int i, input exp_t e);
        if (e.viol || e.abort) m_err[i] = 1'b1;
        if (e.who >= 0) begin
            if (e.finish || e.abort) begin
                m_busy[i] = 1'b0;
                m_last[i] = e.who;
            end else if (!m_busy[i]) begin
                m_busy[i]  = 1'b1;
                m_owner[i] = e.who;
                m_age[i]   = 1;
            end else begin
                m_age[i]++;
            end
        end
    endtask

    function automatic exp_t observe(input int i);
        exp_t a;
        a.who = 0; a.finish = 1'b0; a.abort = 1'b0; a.viol = 1'b0;
        if (i == 0) begin
            a.address = bus_rr.address; a.read = bus_rr.read; a.write = bus_rr.write;
            a.writedata = bus_rr.writedata; a.byteenable = bus_rr.byteenable;
            a.f_wait = rr_f_wait; a.f_rd = rr_f_rd; a.d_wait = rr_d_wait; a.d_rd = rr_d_rd;
            a.grant_d = rr_grant_d; a.bus_error = rr_bus_error;
        end else begin
            a.address = bus_fp.address; a.read = bus_fp.read; a.write = bus_fp.write;
            a.writedata = bus_fp.writedata; a.byteenable = bus_fp.byteenable;
            a.f_wait = fp_f_wait; a.f_rd = fp_f_rd; a.d_wait = fp_d_wait; a.d_rd = fp_d_rd;
            a.grant_d = fp_grant_d; a.bus_error = fp_bus_error;
        end
        return a;
    endfunction

    task automatic cmp(input int i, input exp_t e, input string tag);
        exp_t  a;
        string p;
        a = observe(i);
        p = $sformatf("%s/%s", tag, (i == 0) ? "rr" : "fp");
        chk({p, ".f_wait"},    32'(a.f_wait),    32'(e.f_wait));
        chk({p, ".f_rd"},      a.f_rd,           e.f_rd);
        chk({p, ".d_wait"},    32'(a.d_wait),    32'(e.d_wait));
        chk({p, ".d_rd"},      a.d_rd,           e.d_rd);
        chk({p, ".grant_d"},   32'(a.grant_d),   32'(e.grant_d));
        chk({p, ".bus_error"}, 32'(a.bus_error), 32'(e.bus_error));
        chk({p, ".read"},      32'(a.read),      32'(e.read));
        chk({p, ".write"},     32'(a.write),     32'(e.write));
        if (e.read || e.write) begin
            chk({p, ".address"},    a.address,          e.address);
            chk({p, ".byteenable"}, 32'(a.byteenable),  32'(e.byteenable));
        end
        if (e.write) chk({p, ".writedata"}, a.writedata, e.writedata);
    endtask

    // Inputs are set just after a falling edge; check, clock, advance model.
    task automatic step(input string tag);
        exp_t e [2];
        #1;
        for (int i = 0; i < 2; i++) begin
            e[i] = model_eval(i);
            cmp(i, e[i], tag);
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_update(i, e[i]);
        f_hold = f_read && (e[0].f_wait || e[1].f_wait);
        d_hold = (d_read || d_write) && (e[0].d_wait || e[1].d_wait);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        f_read = 1'b0; f_address = 32'h0;
        d_read = 1'b0; d_write = 1'b0; d_address = 32'h0;
        d_writedata = 32'h0; d_byteenable = 4'h0;
        waitrequest = 1'b0; readdata = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // ---------------- directed vectors (round-robin instance) ----------------
    typedef struct {
        logic        f_read;
        logic [31:0] f_address;
        logic        d_read;
        logic        d_write;
        logic [31:0] d_address;
        logic [31:0] d_writedata;
        logic [3:0]  d_byteenable;
        logic        waitrequest;
        logic [31:0] readdata;
        logic        x_read;
        logic        x_write;
        logic [31:0] x_address;
        logic [3:0]  x_be;
        logic        x_fw;
        logic [31:0] x_frd;
        logic        x_dw;
        logic        x_gd;
        logic        x_gd_fp;
    } vec_t;

    vec_t vt [10];

    initial begin : main
        int found;
        int c;
        logic [1:0] r;

        // fetch only; contention x3; fetch only; D write stalled 3 cycles; F after
        vt[0] = '{1'b1, 32'hBFC00000, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 32'h3C021234,
                  1'b1, 1'b0, 32'hBFC00000, 4'hF, 1'b0, 32'h3C021234, 1'b1, 1'b0, 1'b0};
        vt[1] = '{1'b1, 32'hBFC00004, 1'b1, 1'b0, 32'h2000, 32'h0,        4'hF, 1'b0, 32'h11111111,
                  1'b1, 1'b0, 32'h00002000, 4'hF, 1'b1, 32'h0,        1'b0, 1'b1, 1'b1};
        vt[2] = '{1'b1, 32'hBFC00004, 1'b1, 1'b0, 32'h2000, 32'h0,        4'hF, 1'b0, 32'h22222222,
                  1'b1, 1'b0, 32'hBFC00004, 4'hF, 1'b0, 32'h22222222, 1'b1, 1'b0, 1'b1};
        vt[3] = '{1'b1, 32'hBFC00004, 1'b1, 1'b0, 32'h2000, 32'h0,        4'hF, 1'b0, 32'h33333333,
                  1'b1, 1'b0, 32'h00002000, 4'hF, 1'b1, 32'h0,        1'b0, 1'b1, 1'b1};
        vt[4] = '{1'b1, 32'hBFC00008, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 32'h44444444,
                  1'b1, 1'b0, 32'hBFC00008, 4'hF, 1'b0, 32'h44444444, 1'b1, 1'b0, 1'b0};
        for (int k = 5; k < 8; k++)
            vt[k] = '{1'b1, 32'hBFC0000C, 1'b0, 1'b1, 32'h1000, 32'h06C20000, 4'h3, 1'b1, 32'hDEADBEEF,
                      1'b0, 1'b1, 32'h00001000, 4'h3, 1'b1, 32'h0,    1'b1, 1'b1, 1'b1};
        vt[8] = '{1'b1, 32'hBFC0000C, 1'b0, 1'b1, 32'h1000, 32'h06C20000, 4'h3, 1'b0, 32'h0,
                  1'b0, 1'b1, 32'h00001000, 4'h3, 1'b1, 32'h0,        1'b0, 1'b1, 1'b1};
        vt[9] = '{1'b1, 32'hBFC0000C, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 32'h55555555,
                  1'b1, 1'b0, 32'hBFC0000C, 4'hF, 1'b0, 32'h55555555, 1'b1, 1'b0, 1'b0};

        // reset values with both requesters active
        reset = 1'b1;
        idle_inputs();
        f_read = 1'b1; f_address = 32'hBFC00000;
        d_write = 1'b1; d_address = 32'h1234; d_byteenable = 4'hF;
        model_reset();
        #3;
        chk("rst.read",       32'(bus_rr.read),       32'h0);
        chk("rst.write",      32'(bus_rr.write),      32'h0);
        chk("rst.address",    bus_rr.address,         32'h0);
        chk("rst.writedata",  bus_rr.writedata,       32'h0);
        chk("rst.byteenable", 32'(bus_rr.byteenable), 32'h0);
        chk("rst.f_wait",     32'(rr_f_wait),         32'h1);
        chk("rst.d_wait",     32'(rr_d_wait),         32'h1);
        chk("rst.grant_d",    32'(rr_grant_d),        32'h0);
        chk("rst.bus_error",  32'(rr_bus_error),      32'h0);
        chk("rst.fp_grant_d", 32'(fp_grant_d),        32'h0);
        do_reset();

        for (int k = 0; k < 10; k++) begin
            f_read = vt[k].f_read; f_address = vt[k].f_address;
            d_read = vt[k].d_read; d_write = vt[k].d_write; d_address = vt[k].d_address;
            d_writedata = vt[k].d_writedata; d_byteenable = vt[k].d_byteenable;
            waitrequest = vt[k].waitrequest; readdata = vt[k].readdata;
            #1;
            chk($sformatf("vec%0d.read", k),    32'(bus_rr.read),       32'(vt[k].x_read));
            chk($sformatf("vec%0d.write", k),   32'(bus_rr.write),      32'(vt[k].x_write));
            chk($sformatf("vec%0d.address", k), bus_rr.address,         vt[k].x_address);
            chk($sformatf("vec%0d.be", k),      32'(bus_rr.byteenable), 32'(vt[k].x_be));
            chk($sformatf("vec%0d.f_wait", k),  32'(rr_f_wait),         32'(vt[k].x_fw));
            chk($sformatf("vec%0d.f_rd", k),    rr_f_rd,                vt[k].x_frd);
            chk($sformatf("vec%0d.d_wait", k),  32'(rr_d_wait),         32'(vt[k].x_dw));
            chk($sformatf("vec%0d.grant_d", k), 32'(rr_grant_d),        32'(vt[k].x_gd));
            chk($sformatf("vec%0d.grant_fp", k), 32'(fp_grant_d),       32'(vt[k].x_gd_fp));
            step($sformatf("vec%0d", k));
        end

        // owner drops its request while locked: no grant stealing
        idle_inputs();
        d_read = 1'b1; d_address = 32'h4000; d_byteenable = 4'hF; waitrequest = 1'b1;
        step("drop0");
        d_read = 1'b0; f_read = 1'b1; f_address = 32'hBFC00200;
        #1;
        chk("drop.read",    32'(bus_rr.read), 32'h0);
        chk("drop.grant_d", 32'(rr_grant_d),  32'h1);
        chk("drop.f_wait",  32'(rr_f_wait),   32'h1);
        step("drop1");
        waitrequest = 1'b0; readdata = 32'hA5A5A5A5;
        step("drop2");
        step("drop3");

        // protocol violation: read and write together
        idle_inputs();
        d_read = 1'b1; d_write = 1'b1; d_address = 32'h5000;
        d_writedata = 32'hCAFEF00D; d_byteenable = 4'hC;
        #1;
        chk("viol.write", 32'(bus_rr.write), 32'h1);
        chk("viol.read",  32'(bus_rr.read),  32'h0);
        step("viol0");
        idle_inputs();
        #1;
        chk("viol.bus_error", 32'(rr_bus_error), 32'h1);
        step("viol1");
        f_read = 1'b1; f_address = 32'hBFC00010;
        step("viol2");
        step("viol3");
        chk("viol.sticky", 32'(rr_bus_error), 32'h1);
        do_reset();
        #1;
        chk("viol.cleared", 32'(rr_bus_error), 32'h0);
        @(negedge clk);

        // timeout: F read with waitrequest stuck high
        f_read = 1'b1; f_address = 32'hBFC00100; waitrequest = 1'b1;
        found = 0;
        c = 0;
        while (found == 0 && c < 24) begin
            c++;
            #1;
            if (rr_f_wait === 1'b0) begin
                found = c;
                chk("tmo.read", 32'(bus_rr.read), 32'h0);
                chk("tmo.f_rd", rr_f_rd,          32'h0);
            end
            step("tmo");
        end
        chk("tmo.cycle", 32'(found), 32'd17);
        waitrequest = 1'b0; readdata = 32'h12345678;
        #1;
        chk("tmo.bus_error", 32'(rr_bus_error), 32'h1);
        chk("tmo.next_f_wait", 32'(rr_f_wait), 32'h0);
        step("tmo_next");

        // reset in the middle of a locked transfer
        idle_inputs();
        d_read = 1'b1; d_address = 32'h3000; d_byteenable = 4'hF;
        step("ml0");
        d_address = 32'h3004; waitrequest = 1'b1;
        for (int k = 0; k < 3; k++) step("ml_lock");
        #2;
        reset = 1'b1;
        #1;
        chk("ml.read",       32'(bus_rr.read),        32'h0);
        chk("ml.write",      32'(bus_rr.write),       32'h0);
        chk("ml.address",    bus_rr.address,          32'h0);
        chk("ml.byteenable", 32'(bus_rr.byteenable),  32'h0);
        chk("ml.f_wait",     32'(rr_f_wait),          32'h1);
        chk("ml.d_wait",     32'(rr_d_wait),          32'h1);
        chk("ml.grant_d",    32'(rr_grant_d),         32'h0);
        chk("ml.bus_error",  32'(rr_bus_error),       32'h0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        f_read = 1'b1; f_address = 32'hBFC00300; waitrequest = 1'b0; readdata = 32'h0BADF00D;
        #1;
        chk("ml.d_wins", 32'(rr_grant_d), 32'h1);
        step("ml_after");

        // random traffic; a stalled requester holds its request stable
        idle_inputs();
        f_hold = 1'b0;
        d_hold = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!f_hold) begin
                f_read = 1'($urandom_range(0, 1));
                f_address = $urandom;
            end
            if (!d_hold) begin
                r = 2'($urandom_range(0, 3));
                d_read = (r == 2'd1);
                d_write = (r == 2'd2);
                d_address = $urandom;
                d_writedata = $urandom;
                d_byteenable = 4'($urandom_range(1, 15));
            end
            waitrequest = ($urandom_range(0, 3) == 0);
            readdata = $urandom;
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

endmodule
